// File: rtl/fifo_sync_umbral_pkg.sv
// Shared sizing for the lane FIFOs of the 4x4 arbiter: word width, depth,
// pointer width and the position of the destination-lane field.
package fifo_sync_umbral_pkg;

  localparam int DATA_W   = 10;
  localparam int DEPTH    = 8;
  localparam int ADDR_W   = 3;
  localparam int LANE_MSB = 9;
  localparam int LANE_LSB = 8;

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  function automatic logic [1:0] lane_of(input logic [DATA_W-1:0] word);
    return word[LANE_MSB:LANE_LSB];
  endfunction

endpackage

// File: rtl/fifo_sync_umbral_memoria_dp.sv
// DEPTH x DATA_W register array: synchronous write port, asynchronous read
// port so the head word can fall through without a read latency.
module fifo_sync_umbral_memoria_dp
  import fifo_sync_umbral_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_sync_umbral.sv
// First-word-fall-through synchronous FIFO with programmable almost-full and
// almost-empty thresholds and sticky overflow/underflow flags.
module fifo_sync_umbral
  import fifo_sync_umbral_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_pop,
  input  logic [ADDR_W:0]   i_umbral_alto,
  input  logic [ADDR_W:0]   i_umbral_bajo,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err_overflow,
  output logic              o_err_underflow
);

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_err_overflow;
  logic              r_err_underflow;

  logic              w_empty;
  logic              w_full;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [DATA_W-1:0] w_rd_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // A pop on the same edge frees a slot, so a full FIFO still takes the push.
  assign w_push_ok = i_push && (!w_full || i_pop);
  assign w_pop_ok  = i_pop && !w_empty;

  fifo_sync_umbral_memoria_dp u_mem (
    .i_clk     (i_clk),
    .i_we      (w_push_ok),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (i_data_in),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_err_overflow  <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_push && w_full && !i_pop) begin
        r_err_overflow <= 1'b1;
      end
      if (i_pop && w_empty) begin
        r_err_underflow <= 1'b1;
      end
    end
  end

  assign o_data_out      = w_empty ? '0 : w_rd_data;
  assign o_empty         = w_empty;
  assign o_full          = w_full;
  assign o_alm_full      = (r_count >= i_umbral_alto);
  assign o_alm_empty     = (r_count <= i_umbral_bajo);
  assign o_count         = r_count;
  assign o_err_overflow  = r_err_overflow;
  assign o_err_underflow = r_err_underflow;

endmodule

// File: tb/tb_fifo_sync_umbral.sv
// Self-checking bench for fifo_sync_umbral: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_fifo_sync_umbral;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic [9:0] data_in = '0;
  logic       pop = 1'b0;
  logic [3:0] umbral_alto = 4'd4;
  logic [3:0] umbral_bajo = 4'd1;
  logic [9:0] data_out;
  logic       empty, full, alm_full, alm_empty;
  logic [3:0] count;
  logic       err_overflow, err_underflow;

  int tests = 0;
  int failed = 0;

  logic [9:0] q [$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  fifo_sync_umbral dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_push          (push),
    .i_data_in       (data_in),
    .i_pop           (pop),
    .i_umbral_alto   (umbral_alto),
    .i_umbral_bajo   (umbral_bajo),
    .o_data_out      (data_out),
    .o_empty         (empty),
    .o_full          (full),
    .o_alm_full      (alm_full),
    .o_alm_empty     (alm_empty),
    .o_count         (count),
    .o_err_overflow  (err_overflow),
    .o_err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  // Drive one cycle at the falling edge, let the rising edge act, advance the
  // model by the FIFO rules, then settle 1 time unit before any sampling.
  task automatic applyStimulus(input logic r, input logic pu, input logic [9:0] d, input logic po);
    int n;
    bit do_pop, do_push;
    @(negedge clk);
    rst = r; push = pu; data_in = d; pop = po;
    @(posedge clk);
    n = q.size();
    if (r) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      do_pop  = po && (n > 0);
      do_push = pu && ((n < 8) || po);
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(d);
      if (pu && n == 8 && !po) m_ovf = 1'b1;
      if (po && n == 0) m_unf = 1'b1;
    end
    #1;
    rst = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  function automatic logic [19:0] model_outputs();
    int n = q.size();
    logic [9:0] head = (n > 0) ? q[0] : 10'h000;
    return {head, n == 0, n == 8, n >= int'(umbral_alto), n <= int'(umbral_bajo),
            4'(n), m_ovf, m_unf};
  endfunction

  task automatic test_reset();
    umbral_alto = 4'd4; umbral_bajo = 4'd1;
    applyStimulus(1'b1, 1'b0, 10'h000, 1'b0);
    tests++;
    if ({data_out, empty, full, alm_full, alm_empty, count, err_overflow, err_underflow}
        !== {10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0}) begin
      failed++;
      $display("[TB] FAIL reset_state: got data=%h e=%b f=%b af=%b ae=%b cnt=%0d ovf=%b unf=%b expected data=000 e=1 f=0 af=0 ae=1 cnt=0 ovf=0 unf=0",
               data_out, empty, full, alm_full, alm_empty, count, err_overflow, err_underflow);
    end
    umbral_alto = 4'd0;
    #1;
    tests++;
    if (alm_full !== 1'b1) begin
      failed++;
      $display("[TB] FAIL reset_alto_zero: got alm_full=%b expected 1", alm_full);
    end
    umbral_alto = 4'd4;
  endtask

  task automatic test_fill_thresholds();
    logic [9:0] words [4] = '{10'h0CC, 10'h1CC, 10'h2CC, 10'h3CC};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b1, words[i], 1'b0);
      if (i == 2) begin
        tests++;
        if (alm_full !== 1'b0 || count !== 4'd3) begin
          failed++;
          $display("[TB] FAIL alm_full_below: got af=%b cnt=%0d expected af=0 cnt=3", alm_full, count);
        end
      end
    end
    tests++;
    if (count !== 4'd4 || alm_full !== 1'b1 || data_out !== 10'h0CC || alm_empty !== 1'b0) begin
      failed++;
      $display("[TB] FAIL fill4: got cnt=%0d af=%b data=%h ae=%b expected cnt=4 af=1 data=0cc ae=0",
               count, alm_full, data_out, alm_empty);
    end
  endtask

  task automatic test_drain();
    logic [9:0] seq [4] = '{10'h0CC, 10'h1CC, 10'h2CC, 10'h3CC};
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (data_out !== seq[i]) begin
        failed++;
        $display("[TB] FAIL drain_head%0d: got %h expected %h", i, data_out, seq[i]);
      end
      applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    end
    tests++;
    if (empty !== 1'b1 || data_out !== 10'h000 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL drain_end: got e=%b data=%h ovf=%b unf=%b expected e=1 data=000 ovf=0 unf=0",
               empty, data_out, err_overflow, err_underflow);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, 10'($urandom_range(0, 10'h3FE)), 1'b0);
    end
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || err_overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL fill8: got f=%b cnt=%0d ovf=%b expected f=1 cnt=8 ovf=0", full, count, err_overflow);
    end
    applyStimulus(1'b0, 1'b1, 10'h3FF, 1'b0);
    tests++;
    if (full !== 1'b1 || count !== 4'd8 || err_overflow !== 1'b1) begin
      failed++;
      $display("[TB] FAIL overflow: got f=%b cnt=%0d ovf=%b expected f=1 cnt=8 ovf=1", full, count, err_overflow);
    end
  endtask

  task automatic test_full_push_pop();
    logic [9:0] last;
    applyStimulus(1'b0, 1'b1, 10'h155, 1'b1);
    tests++;
    if (count !== 4'd8 || err_overflow !== 1'b1 || err_underflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL full_push_pop: got cnt=%0d ovf=%b unf=%b expected cnt=8 ovf=1 unf=0",
               count, err_overflow, err_underflow);
    end
    last = 10'h000;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (data_out !== q[0] || data_out === 10'h3FF) begin
        failed++;
        $display("[TB] FAIL full_drain%0d: got %h expected %h", i, data_out, q[0]);
      end
      last = data_out;
      applyStimulus(1'b0, 1'b0, 10'h000, 1'b1);
    end
    tests++;
    if (last !== 10'h155 || empty !== 1'b1) begin
      failed++;
      $display("[TB] FAIL last_word: got %h e=%b expected 155 e=1", last, empty);
    end
  endtask

  task automatic test_underflow();
    applyStimulus(1'b0, 1'b1, 10'h2AA, 1'b1);
    tests++;
    if (err_underflow !== 1'b1 || count !== 4'd1 || data_out !== 10'h2AA) begin
      failed++;
      $display("[TB] FAIL underflow: got unf=%b cnt=%0d data=%h expected unf=1 cnt=1 data=2aa",
               err_underflow, count, data_out);
    end
  endtask

  task automatic test_reset_wrap();
    logic [9:0] w;
    while (q.size() < 5) applyStimulus(1'b0, 1'b1, 10'($urandom), 1'b0);
    applyStimulus(1'b1, 1'b1, 10'h123, 1'b0);
    tests++;
    if (count !== 4'd0 || empty !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL reset_mid: got cnt=%0d e=%b ovf=%b unf=%b expected cnt=0 e=1 ovf=0 unf=0",
               count, empty, err_overflow, err_underflow);
    end
    applyStimulus(1'b0, 1'b1, 10'h001, 1'b0);
    for (int i = 0; i < 12; i++) begin
      w = 10'($urandom);
      tests++;
      if (data_out !== q[0]) begin
        failed++;
        $display("[TB] FAIL wrap%0d: got %h expected %h", i, data_out, q[0]);
      end
      applyStimulus(1'b0, 1'b1, w, 1'b1);
    end
    tests++;
    if (count !== 4'd1 || data_out !== q[0] || err_underflow !== 1'b0 || err_overflow !== 1'b0) begin
      failed++;
      $display("[TB] FAIL wrap_end: got cnt=%0d data=%h unf=%b ovf=%b expected cnt=1 data=%h unf=0 ovf=0",
               count, data_out, err_underflow, err_overflow, q[0]);
    end
  endtask

  task automatic test_random();
    logic [19:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        umbral_alto = 4'($urandom_range(0, 15));
        umbral_bajo = 4'($urandom_range(0, 15));
      end
      applyStimulus($urandom_range(0, 99) == 0, 1'($urandom), 10'($urandom), 1'($urandom));
      got = {data_out, empty, full, alm_full, alm_empty, count, err_overflow, err_underflow};
      exp = model_outputs();
      tests++;
      if (got !== exp) begin
        failed++;
        $display("[TB] FAIL random%0d: got %h expected %h (data,e,f,af,ae,cnt,ovf,unf)", i, got, exp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_thresholds();
    test_drain();
    test_overflow();
    test_full_push_pop();
    test_underflow();
    test_reset_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
